// File: rtl/axi_slave_mem_pkg.sv
// Shared response codes and FSM state types for the axi_slave_mem responder.
package axi_slave_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
// Optional per-word user column when AXI_SLAVE_MEM_USER_EN is defined.
module axi_slave_mem_ram #(
    parameter int WORD_AW    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [WORD_AW-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [USER_WIDTH-1:0]   wuser,
    input  logic                    re,
    input  logic [WORD_AW-1:0]      raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [USER_WIDTH-1:0]   ruser
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef AXI_SLAVE_MEM_USER_EN
    logic [USER_WIDTH-1:0] mem_user [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_user[waddr] <= wuser;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ruser <= '0;
        end else if (re) begin
            ruser <= mem_user[raddr];
        end
    end
`else
    logic unused_user;
    assign unused_user = ^wuser;
    assign ruser       = '0;
`endif

endmodule

// File: rtl/axi_slave_mem.sv
// AXI INCR-burst memory responder with independent write and read channels.
// AXI_SLAVE_MEM_USER_EN adds stored user sideband (ruser/buser).
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic [USER_WIDTH-1:0]   wuser,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic [USER_WIDTH-1:0]   buser,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [USER_WIDTH-1:0]   ruser,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int BSH     = $clog2(BYTES);
    localparam int WORD_AW = ADDR_WIDTH - BSH;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;
    logic    active;

    logic [WORD_AW-1:0] widx, ridx, ram_raddr;
    logic [7:0]         wcnt, rcnt;
    logic               werr, rlast_q;
    logic [1:0]         bresp_q;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic               w_final, wlast_bad, ram_re;
    logic               unused_addr;

    assign unused_addr = ^{awaddr, araddr};

    // active keeps the IDLE readies low for the whole time reset is asserted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
            active <= 1'b0;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
            active <= 1'b1;
        end
    end

    always_comb begin
        wstate_nxt = wstate;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (wstate)
            W_IDLE: begin
                awready = active;
                if (active && awvalid) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_final) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_nxt = rstate;
        arready    = 1'b0;
        rvalid     = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = active;
                if (active && arvalid) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast_q) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign aw_hs     = awready & awvalid;
    assign w_hs      = wready & wvalid;
    assign b_hs      = bvalid & bready;
    assign ar_hs     = arready & arvalid;
    assign r_hs      = rvalid & rready;
    assign w_final   = (wcnt == 8'd0);
    assign wlast_bad = (wlast != w_final);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            widx    <= '0;
            wcnt    <= '0;
            werr    <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else if (aw_hs) begin
            widx <= awaddr[ADDR_WIDTH-1:BSH];
            wcnt <= awlen;
            werr <= 1'b0;
        end else if (w_hs) begin
            widx <= widx + 1'b1;
            if (wlast_bad) werr <= 1'b1;
            if (w_final) begin
                bresp_q <= (werr || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
                wcnt <= wcnt - 8'd1;
            end
        end
    end

    // ridx always points at the word to fetch for the next beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ridx    <= '0;
            rcnt    <= '0;
            rlast_q <= 1'b0;
        end else if (ar_hs) begin
            ridx    <= araddr[ADDR_WIDTH-1:BSH] + 1'b1;
            rcnt    <= arlen;
            rlast_q <= (arlen == 8'd0);
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                ridx    <= ridx + 1'b1;
                rcnt    <= rcnt - 8'd1;
                rlast_q <= (rcnt == 8'd1);
            end
        end
    end

    assign ram_raddr = (rstate == R_IDLE) ? araddr[ADDR_WIDTH-1:BSH] : ridx;
    assign ram_re    = ar_hs | (r_hs & ~rlast_q);

    axi_slave_mem_ram #(
        .WORD_AW   (WORD_AW),
        .DATA_WIDTH(DATA_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_ram (
        .clk  (aclk),
        .rst_n(aresetn),
        .we   (w_hs),
        .waddr(widx),
        .wdata(wdata),
        .wstrb(wstrb),
        .wuser(wuser),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(rdata),
        .ruser(ruser)
    );

`ifdef AXI_SLAVE_MEM_USER_EN
    logic [USER_WIDTH-1:0] buser_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            buser_q <= '0;
        end else if (w_hs && w_final) begin
            buser_q <= wuser;
        end
    end

    assign buser = buser_q;
`else
    assign buser = '0;
`endif

    assign bresp = bresp_q;
    assign rresp = RESP_OKAY;
    assign rlast = rlast_q;

    logic unused_b;
    assign unused_b = b_hs;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: vector table, directed corner cases,
// and randomized bursts against a word-array reference model.
module tb_axi_slave_mem;

`ifdef AXI_SLAVE_MEM_USER_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [9:0]  awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [0:0]  wuser, buser, ruser;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_slave_mem #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .USER_WIDTH(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    // Reference model: one entry per 32-bit word, plus user bit.
    logic [31:0] mm [256];
    logic        mu [256];

    // Per-beat write stimulus and captured read beats.
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];
    logic        wu [256];
    logic [31:0] rd_buf [256];

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [7:0] len, output logic [1:0] br);
        int n;
        logic exp_err;
        logic [7:0] idx;
        exp_err = 1'b0;
        idx     = addr[9:2];
        awaddr  = addr;
        awlen   = len;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick; n++; end
        if (n >= 50) timeout_fail("aw_wait");
        tick;
        awvalid = 1'b0;
        check("wready_after_aw", wready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = wl[b]; wuser = wu[b];
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin tick; n++; end
            if (n >= 50) timeout_fail("w_wait");
            tick;
            wvalid = 1'b0;
            for (int k = 0; k < 4; k++)
                if (ws[b][k]) mm[idx][k*8 +: 8] = wd[b][k*8 +: 8];
            mu[idx] = wu[b];
            if (wl[b] != (b == int'(len))) exp_err = 1'b1;
            idx++;
        end
        check("bvalid_after_last_w", bvalid, 1);
        check("bresp", bresp, exp_err ? 2'b10 : 2'b00);
        check("buser", buser, USER_EN ? wu[len] : 1'b0);
        br = bresp;
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("awready_after_b", awready, 1);
    endtask

    task automatic do_read(input logic [9:0] addr, input logic [7:0] len, input bit toggle);
        int n;
        logic [7:0] idx;
        idx     = addr[9:2];
        araddr  = addr;
        arlen   = len;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick; n++; end
        if (n >= 50) timeout_fail("ar_wait");
        tick;
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (toggle) begin
                rready = 1'b0;
                tick;
                check("r_stall_data", {rlast, rdata}, {b == int'(len), mm[idx]});
            end
            rready = 1'b1;
            check("rvalid", rvalid, 1);
            check("rdata", rdata, mm[idx]);
            check("rlast", rlast, b == int'(len));
            check("ruser", ruser, USER_EN ? mu[idx] : 1'b0);
            rd_buf[b] = rdata;
            tick;
            rready = 1'b0;
            idx++;
        end
        check("arready_after_last_r", {arready, rvalid}, 2'b10);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, buser, ruser, rdata},
              '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] br;
        logic [31:0] old_val;

        tbl[0] = '{10'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        tbl[1] = '{10'h020, 32'h11223344, 4'hF, 32'h11223344};
        tbl[2] = '{10'h020, 32'hAABBCCDD, 4'h5, 32'h11BB33DD};
        tbl[3] = '{10'h023, 32'h00000000, 4'h0, 32'h11BB33DD};
        tbl[4] = '{10'h022, 32'hFFFFFFFF, 4'h8, 32'hFFBB33DD};
        tbl[5] = '{10'h3FC, 32'h12345678, 4'h3, 32'hA5005678};

        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wuser = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick;
        check_reset_outputs("reset_outputs");
        aresetn = 1'b1;
        tick;
        check("ready_after_reset", {awready, arready}, 2'b11);

        // Fill the whole memory with a known pattern: word i = A50000ii.
        for (int i = 0; i < 256; i++) begin
            wd[i] = 32'hA5000000 | i;
            ws[i] = 4'hF;
            wl[i] = (i == 255);
            wu[i] = i[0];
        end
        do_write(10'h000, 8'd255, br);

        for (int i = 0; i < 6; i++) begin
            wd[0] = tbl[i].data; ws[0] = tbl[i].strb; wl[0] = 1'b1; wu[0] = i[0];
            do_write(tbl[i].addr, 8'd0, br);
            check("tbl_bresp", br, 2'b00);
            do_read(tbl[i].addr, 8'd0, 1'b0);
            check("tbl_rdata", rd_buf[0], tbl[i].exp);
        end

        // Wrap from the top word to word 0.
        for (int i = 0; i < 4; i++) begin
            wd[i] = i + 1; ws[i] = 4'hF; wl[i] = (i == 3); wu[i] = 1'b1;
        end
        do_write(10'h3F8, 8'd3, br);
        do_read(10'h3F8, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) check("wrap_data", rd_buf[i], i + 1);
        do_read(10'h000, 8'd0, 1'b0);
        check("wrap_word0", rd_buf[0], 32'd3);

        // Early wlast: error response, all beats still written.
        for (int i = 0; i < 3; i++) begin
            wd[i] = 32'hE0000000 + i; ws[i] = 4'hF; wu[i] = 1'b0;
        end
        wl[0] = 1'b1; wl[1] = 1'b0; wl[2] = 1'b1;
        do_write(10'h040, 8'd2, br);
        check("wlast_err_bresp", br, 2'b10);
        do_read(10'h040, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) check("wlast_err_data", rd_buf[i], 32'hE0000000 + i);
        wl[0] = 1'b0; wl[1] = 1'b0; wl[2] = 1'b1;
        do_write(10'h040, 8'd2, br);
        check("wlast_ok_bresp", br, 2'b00);

        // Concurrent write and stalled read on disjoint regions.
        for (int i = 0; i < 8; i++) begin
            wd[i] = 32'hC0DE0000 + i; ws[i] = 4'hF; wl[i] = (i == 7); wu[i] = 1'b1;
        end
        fork
            do_write(10'h200, 8'd7, br);
            do_read(10'h300, 8'd7, 1'b1);
        join
        do_read(10'h200, 8'd7, 1'b0);
        for (int i = 0; i < 8; i++) check("concurrent_wdata", rd_buf[i], 32'hC0DE0000 + i);

        // Same-word write and read accepted on the same edge: read-first.
        old_val = mm[10];
        awaddr = 10'h028; awlen = 8'd0; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wlast = 1'b1; wuser = 1'b0; wvalid = 1'b1;
        araddr = 10'h028; arlen = 8'd0; arvalid = 1'b1;
        check("collision_setup", {wready, arready}, 2'b11);
        tick;
        wvalid = 1'b0; arvalid = 1'b0;
        mm[10] = 32'h5A5A5A5A; mu[10] = 1'b0;
        check("collision_old", rdata, old_val);
        check("collision_b", {bvalid, rvalid, rlast}, 3'b111);
        rready = 1'b1; bready = 1'b1;
        tick;
        rready = 1'b0; bready = 1'b0;
        do_read(10'h028, 8'd0, 1'b0);
        check("collision_new", rd_buf[0], 32'h5A5A5A5A);

        // Reset after two of four write beats.
        awaddr = 10'h100; awlen = 8'd3; awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = 32'h0BAD0001 + b; wstrb = 4'hF; wlast = 1'b0; wuser = 1'b1; wvalid = 1'b1;
            tick;
            mm[64 + b] = 32'h0BAD0001 + b; mu[64 + b] = 1'b1;
        end
        wvalid = 1'b0;
        aresetn = 1'b0;
        tick;
        check_reset_outputs("midburst_reset_outputs");
        aresetn = 1'b1;
        tick;
        check("midburst_ready_after_release", {awready, arready, wready, bvalid}, 4'b1100);
        do_read(10'h100, 8'd3, 1'b0);
        check("midburst_beat0", rd_buf[0], 32'h0BAD0001);

        // Randomized bursts checked against the model.
        for (int it = 0; it < 20; it++) begin
            logic [7:0] len;
            logic [9:0] addr;
            int j;
            len  = 8'($urandom_range(0, 15));
            addr = 10'($urandom_range(0, 1023));
            for (int b = 0; b <= int'(len); b++) begin
                wd[b] = $urandom;
                ws[b] = 4'($urandom_range(0, 15));
                wl[b] = (b == int'(len));
                wu[b] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, int'(len));
                wl[j] = ~wl[j];
            end
            do_write(addr, len, br);
            if ($urandom_range(0, 1) == 0) addr = 10'($urandom_range(0, 1023));
            do_read(addr, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
